// File: rtl/dds_interp_quarter.sv
// DDS phase accumulator with quarter-wave folding into an external sine table and linear interpolation.
// Optional LFSR phase dither before truncation is enabled by defining DDS_PHASE_DITHER_EN.
module dds_interp_quarter #(
  parameter int          PHASE_WIDTH   = 24,
  parameter int          ADDRESS_WIDTH = 10,
  parameter int          INTERP_WIDTH  = 8,
  parameter int          VALUE_WIDTH   = 12,
  parameter int unsigned INITIAL_STEP  = 32'd1,
  parameter int          TABLE_DELAY   = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          SET,
  input  logic                          set_mode,
  input  logic [PHASE_WIDTH-1:0]        step_in,
  input  logic [PHASE_WIDTH-1:0]        phase_offset,
  input  logic                          enable,
  output logic [ADDRESS_WIDTH-3:0]      tbl_addr_a,
  output logic [ADDRESS_WIDTH-3:0]      tbl_addr_b,
  input  logic [VALUE_WIDTH-2:0]        tbl_data_a,
  input  logic [VALUE_WIDTH-2:0]        tbl_data_b,
  output logic signed [VALUE_WIDTH-1:0] value,
  output logic                          value_valid,
  output logic                          zero_phase
);

  localparam int KW  = ADDRESS_WIDTH - 2;
  localparam int MW  = VALUE_WIDTH - 1;
  localparam int TW  = PHASE_WIDTH - ADDRESS_WIDTH - INTERP_WIDTH;
  localparam int SBW = INTERP_WIDTH + 5;
  localparam logic [MW-1:0] VMAX = {MW{1'b1}};

  logic [PHASE_WIDTH-1:0] acc_q, acc_d, step_q, step_d, phase_s;

  always_comb begin
    acc_d  = acc_q;
    step_d = step_q;
    if (SET) begin
      step_d = step_in;
      if (set_mode) acc_d = acc_q + step_q;
      else          acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + step_q;
    end else begin
      acc_d  = acc_q;
      step_d = step_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_q  <= '0;
      step_q <= PHASE_WIDTH'(INITIAL_STEP);
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITHER_W = (TW > 16) ? 16 : TW;
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_lfsr_s;
  assign lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign unused_lfsr_s = ^lfsr_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  if (DITHER_W > 0) begin : g_dither
    assign phase_s = acc_q + phase_offset + PHASE_WIDTH'(lfsr_q[DITHER_W-1:0]);
  end else begin : g_no_dither
    assign phase_s = acc_q + phase_offset;
  end
`else
  assign phase_s = acc_q + phase_offset;
`endif

  logic [1:0]              quad_s;
  logic [KW-1:0]           idx_s, k_s;
  logic [INTERP_WIDTH-1:0] f_s, frac_s;

  assign quad_s = phase_s[PHASE_WIDTH-1 -: 2];
  assign idx_s  = phase_s[PHASE_WIDTH-3 -: KW];
  assign f_s    = phase_s[PHASE_WIDTH-ADDRESS_WIDTH-1 -: INTERP_WIDTH];

  if (TW > 0) begin : g_trunc
    logic unused_trunc_s;
    assign unused_trunc_s = ^phase_s[TW-1:0];
  end

  // Odd quadrants run the table backwards; one's complement mirrors both index and fraction.
  always_comb begin
    k_s    = idx_s;
    frac_s = f_s;
    if (quad_s[0]) begin
      k_s    = ~idx_s;
      frac_s = ~f_s;
    end else begin
      k_s    = idx_s;
      frac_s = f_s;
    end
  end

  logic [KW-1:0]  addr_a_q, addr_b_q;
  logic [SBW-1:0] sb1_q;
  logic [SBW-1:0] sb_dly_q [TABLE_DELAY];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      sb1_q    <= '0;
    end else begin
      addr_a_q <= k_s;
      addr_b_q <= k_s + KW'(1);
      sb1_q    <= {quad_s, frac_s, &k_s, (acc_q == '0), (enable | SET)};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < TABLE_DELAY; i++) sb_dly_q[i] <= '0;
    end else begin
      sb_dly_q[0] <= sb1_q;
      for (int i = 1; i < TABLE_DELAY; i++) sb_dly_q[i] <= sb_dly_q[i-1];
    end
  end

  assign tbl_addr_a = addr_a_q;
  assign tbl_addr_b = addr_b_q;

  logic [SBW-1:0]             sbt_s;
  logic [1:0]                 quad_t_s;
  logic [INTERP_WIDTH-1:0]    frac_t_s;
  logic                       peak_t_s, zero_t_s, valid_t_s;
  logic [MW-1:0]              b_s, diff_s, mag_d;
  logic [MW+INTERP_WIDTH-1:0] prod_s;
  logic                       unused_prod_s;

  assign sbt_s     = sb_dly_q[TABLE_DELAY-1];
  assign quad_t_s  = sbt_s[SBW-1 -: 2];
  assign frac_t_s  = sbt_s[SBW-3 -: INTERP_WIDTH];
  assign peak_t_s  = sbt_s[2];
  assign zero_t_s  = sbt_s[1];
  assign valid_t_s = sbt_s[0];

  // The last entry interpolates toward full scale, which is not stored in the table.
  assign b_s           = peak_t_s ? VMAX : tbl_data_b;
  assign diff_s        = b_s - tbl_data_a;
  assign prod_s        = {{INTERP_WIDTH{1'b0}}, diff_s} * {{MW{1'b0}}, frac_t_s};
  assign mag_d         = tbl_data_a + prod_s[MW+INTERP_WIDTH-1 -: MW];
  assign unused_prod_s = ^prod_s[INTERP_WIDTH-1:0];

  logic [MW-1:0] mag_q;
  logic [1:0]    quad2_q;
  logic          zero2_q, valid2_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mag_q    <= '0;
      quad2_q  <= '0;
      zero2_q  <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      quad2_q  <= quad_t_s;
      zero2_q  <= zero_t_s;
      valid2_q <= valid_t_s;
    end
  end

  logic signed [VALUE_WIDTH-1:0] mag_ext_s, value_d, value_q;
  logic                          value_valid_q, zero_phase_q;

  assign mag_ext_s = {1'b0, mag_q};

  always_comb begin
    value_d = mag_ext_s;
    if (quad2_q[1]) value_d = -mag_ext_s;
    else            value_d = mag_ext_s;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      value_q       <= '0;
      value_valid_q <= 1'b0;
      zero_phase_q  <= 1'b0;
    end else begin
      value_q       <= value_d;
      value_valid_q <= valid2_q;
      zero_phase_q  <= zero2_q;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign zero_phase  = zero_phase_q;

endmodule

// File: tb/tb_dds_interp_quarter.sv
// Self-checking bench for dds_interp_quarter: sine ROM with 2-cycle latency and a sample-level reference model.
module tb_dds_interp_quarter;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               SET = 1'b0;
  logic               set_mode = 1'b0;
  logic               enable = 1'b0;
  logic [23:0]        step_in = 24'd0;
  logic [23:0]        phase_offset = 24'd0;
  logic [7:0]         tbl_addr_a, tbl_addr_b;
  logic [10:0]        tbl_data_a, tbl_data_b;
  logic signed [11:0] value;
  logic               value_valid, zero_phase;

  int checks = 0;
  int failures = 0;
  int tbl [0:255];
  int peak_seen = 0;

  dds_interp_quarter dut (
    .CLK(CLK), .RESET(RESET), .SET(SET), .set_mode(set_mode),
    .step_in(step_in), .phase_offset(phase_offset), .enable(enable),
    .tbl_addr_a(tbl_addr_a), .tbl_addr_b(tbl_addr_b),
    .tbl_data_a(tbl_data_a), .tbl_data_b(tbl_data_b),
    .value(value), .value_valid(value_valid), .zero_phase(zero_phase)
  );

  always #5 CLK = ~CLK;

  // External quarter-sine ROM, two registered stages
  logic [10:0] ra1 = 11'd0, ra2 = 11'd0, rb1 = 11'd0, rb2 = 11'd0;
  always @(posedge CLK) begin
    ra1 <= 11'(tbl[tbl_addr_a]);
    ra2 <= ra1;
    rb1 <= 11'(tbl[tbl_addr_b]);
    rb2 <= rb1;
  end
  assign tbl_data_a = ra2;
  assign tbl_data_b = rb2;

  function automatic logic signed [11:0] ref_sample(input logic [23:0] p);
    int unsigned pv;
    int q, idx, f, k, fr, a, b, mag;
    pv  = p;
    q   = int'(pv / 4194304);
    idx = int'((pv / 16384) % 256);
    f   = int'((pv / 64) % 256);
    if (q == 1 || q == 3) begin k = 255 - idx; fr = 255 - f; end
    else begin k = idx; fr = f; end
    a   = tbl[k];
    b   = (k == 255) ? 2047 : tbl[k + 1];
    mag = a + ((b - a) * fr) / 256;
    if (q >= 2) mag = -mag;
    return 12'(mag);
  endfunction

  // Reference: accumulator rules plus a five-sample output delay
  logic [23:0]        m_acc = 24'd0, m_step = 24'd1;
  logic signed [11:0] ev  [0:4];
  logic               evv [0:4];
  logic               ez  [0:4];
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_acc  <= 24'd0;
      m_step <= 24'd1;
      for (int i = 0; i < 5; i++) begin ev[i] <= 12'sd0; evv[i] <= 1'b0; ez[i] <= 1'b0; end
    end else begin
      ev[0]  <= ref_sample(24'(m_acc + phase_offset));
      evv[0] <= enable | SET;
      ez[0]  <= (m_acc == 24'd0);
      for (int i = 1; i < 5; i++) begin ev[i] <= ev[i-1]; evv[i] <= evv[i-1]; ez[i] <= ez[i-1]; end
      if (SET) begin
        m_step <= step_in;
        m_acc  <= set_mode ? 24'(m_acc + m_step) : 24'd0;
      end else if (enable) begin
        m_acc <= 24'(m_acc + m_step);
      end
    end
  end

  task automatic test_reset();
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (value !== 12'sd0)     begin failures++; $display("FAIL reset_value got=%0d exp=0", value); end
    checks++; if (value_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", value_valid); end
    checks++; if (zero_phase !== 1'b0)  begin failures++; $display("FAIL reset_zero got=%b exp=0", zero_phase); end
    checks++; if (tbl_addr_a !== 8'd0)  begin failures++; $display("FAIL reset_addr_a got=%0d exp=0", tbl_addr_a); end
    checks++; if (tbl_addr_b !== 8'd0)  begin failures++; $display("FAIL reset_addr_b got=%0d exp=0", tbl_addr_b); end
    RESET = 1'b1;
  endtask

  task automatic test_zero_step();
    SET = 1'b1; set_mode = 1'b0; step_in = 24'd0; enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      SET = 1'b0;
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL zs_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      checks++; if (zero_phase !== ez[4]) begin failures++; $display("FAIL zs_zero cyc=%0d got=%b exp=%b", i, zero_phase, ez[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL zs_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      checks++;
      if (value_valid !== (i >= 5)) begin failures++; $display("FAIL zs_latency cyc=%0d got=%b exp=%b", i, value_valid, (i >= 5)); end
      if (i >= 5) begin
        checks++; if (value !== 12'sd0 || zero_phase !== 1'b1) begin failures++; $display("FAIL zs_const cyc=%0d got=%0d/%b exp=0/1", i, value, zero_phase); end
      end
    end
  endtask

  task automatic test_quarter_wave();
    int v;
    SET = 1'b1; set_mode = 1'b0; step_in = 24'h400000; enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      SET = 1'b0;
      v = value;
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL qw_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      checks++; if (zero_phase !== ez[4]) begin failures++; $display("FAIL qw_zero cyc=%0d got=%b exp=%b", i, zero_phase, ez[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL qw_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      if (i >= 6) begin
        checks++;
        case ((i - 6) % 4)
          1: begin
            peak_seen = v;
            if (v < 2040 || v > 2047) begin failures++; $display("FAIL qw_peak cyc=%0d got=%0d exp=2040..2047", i, v); end
          end
          3: if (v !== -peak_seen) begin failures++; $display("FAIL qw_negpeak cyc=%0d got=%0d exp=%0d", i, v, -peak_seen); end
          default: if (v !== 0) begin failures++; $display("FAIL qw_zero_cross cyc=%0d got=%0d exp=0", i, v); end
        endcase
      end
    end
  endtask

  task automatic test_half_entry();
    int v, j, e;
    SET = 1'b1; set_mode = 1'b0; step_in = 24'h002000; enable = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      @(negedge CLK);
      SET = 1'b0;
      v = value;
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL he_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL he_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      if (i >= 6) begin
        j = i - 6;
        e = (j % 2 == 0) ? tbl[j / 2] : (tbl[j / 2] + tbl[j / 2 + 1]) / 2;
        checks++; if (v !== e) begin failures++; $display("FAIL he_interp j=%0d got=%0d exp=%0d", j, v, e); end
      end
    end
  endtask

  task automatic test_continuous_set();
    SET = 1'b1; set_mode = 1'b0; step_in = 24'h010000; enable = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge CLK);
      SET = (i == 10); set_mode = 1'b1; step_in = (i >= 10) ? 24'h020000 : 24'h010000;
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL cs_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      checks++; if (zero_phase !== ez[4]) begin failures++; $display("FAIL cs_zero cyc=%0d got=%b exp=%b", i, zero_phase, ez[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL cs_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
    end
    SET = 1'b0;
  endtask

  task automatic test_offset_restart();
    phase_offset = 24'h400000; SET = 1'b1; set_mode = 1'b0; step_in = 24'h020000; enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      SET = 1'b0;
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL or_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL or_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      if (i == 6) begin
        checks++; if (value !== 12'(peak_seen)) begin failures++; $display("FAIL or_first got=%0d exp=%0d", value, peak_seen); end
        checks++; if (zero_phase !== 1'b1) begin failures++; $display("FAIL or_zero got=%b exp=1", zero_phase); end
      end
    end
  endtask

  task automatic test_async_reset();
    SET = 1'b0; enable = 1'b1;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    checks++; if (value !== 12'sd0)     begin failures++; $display("FAIL ar_value got=%0d exp=0", value); end
    checks++; if (value_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", value_valid); end
    @(negedge CLK);
    phase_offset = 24'd0; enable = 1'b1;
    #2 RESET = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL ar_model_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL ar_model_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      checks++; if (value_valid !== (i >= 5)) begin failures++; $display("FAIL ar_latency cyc=%0d got=%b exp=%b", i, value_valid, (i >= 5)); end
      if (i == 5) begin checks++; if (value !== 12'sd0) begin failures++; $display("FAIL ar_first got=%0d exp=0", value); end end
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      @(negedge CLK);
      checks++; if (value_valid !== evv[4]) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, value_valid, evv[4]); end
      checks++; if (zero_phase !== ez[4]) begin failures++; $display("FAIL rnd_zero cyc=%0d got=%b exp=%b", i, zero_phase, ez[4]); end
      if (evv[4]) begin checks++; if (value !== ev[4]) begin failures++; $display("FAIL rnd_value cyc=%0d got=%0d exp=%0d", i, value, ev[4]); end end
      SET      = ($urandom % 8 == 0);
      set_mode = 1'($urandom % 2);
      step_in  = ($urandom % 2 == 1) ? 24'($urandom) : 24'($urandom % 65536);
      enable   = ($urandom % 4 != 0);
      if ($urandom % 16 == 0) phase_offset = 24'($urandom);
    end
    SET = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      tbl[k] = $rtoi($floor(2047.0 * $sin(3.14159265358979 * 0.5 * k / 256.0) + 0.5));
    test_reset();
    test_zero_step();
    test_quarter_wave();
    test_half_entry();
    test_continuous_set();
    test_offset_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
